hex_key_entry: RTL
==================

# hex_key_entry

Debounced push-button hex digit entry for the 50 MHz board top. The block samples the user's pushbuttons and the low switch nibble, and builds an 8-digit hex value from them. That value feeds the per-digit 7-segment encoders, and the block is the input-side counterpart of the display path. Each button press produces exactly one edit: enter, backspace or clear.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required before a key state change is accepted; 20 ms at 50 MHz. Minimum 2.
- NDIGITS, default 8: number of hex digits held.
- CLOCK_50, in, 1: the single clock, 50 MHz. All logic is on the rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- key_n, in, 3: raw active-low pushbuttons, asynchronous to the clock. Bit 0 is ENTER, bit 1 is BACKSPACE, bit 2 is CLEAR.
- sw_digit, in, 4: hex digit to enter, sampled in the event cycle. Switches are quasi-static, so there is no synchronizer.
- digits, out, 4*NDIGITS: entered value. Digit 0 is the newest and sits at [3:0].
- count, out, 4: number of digits entered, 0..NDIGITS.
- full, out, 1: high when count == NDIGITS.
- entry_valid, out, 1: one-cycle pulse when an ENTER is accepted.
- key_event, out, 3: one-cycle press pulses after debounce, one bit per key.

## Operation
- Reset values: digits = 0, count = 0, full = 0, entry_valid = 0, key_event = 0. Synchronizers and stable states reset to released (1). Debounce counters reset to 0.
- Each key_n bit passes through a 2-FF synchronizer, then an independent debounce FSM:
  - RELEASED: when sync = 0, clear the counter and go to ARM_PRESS.
  - ARM_PRESS: while sync = 0, count up. If sync = 1, return to RELEASED and clear the counter. When the counter reaches DEBOUNCE_CYCLES−1, go to PRESSED and pulse key_event for one cycle.
  - PRESSED: when sync = 1, clear the counter and go to ARM_RELEASE.
  - ARM_RELEASE: mirror of ARM_PRESS. When the counter reaches the terminal count, go to RELEASED with no pulse. If sync = 0 in between, return to PRESSED.
- Holding a key produces one event. There is no auto-repeat.
- Event actions, applied in the cycle after key_event:
  - CLEAR: digits = 0, count = 0.
  - BACKSPACE with count > 0: digits shift right by 4 with zero fill at the top, and count decrements. With count = 0 it is ignored.
  - ENTER with count < NDIGITS: digits = {digits[4*NDIGITS−5:0], sw_digit}, count increments, and entry_valid pulses. When full, see Configuration.
- Simultaneous events in the same cycle are resolved by priority CLEAR > BACKSPACE > ENTER. Lower-priority events are dropped.
- full is derived from the count register, so it updates in the same cycle as count.

## Timing
- Press latency: if key_n is first sampled low at edge k and stays low, key_event rises at edge k + 2 + DEBOUNCE_CYCLES.
- digits, count and entry_valid update one edge later, at k + 3 + DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- Release requires the same stable time. A new press is accepted only after the release has been accepted.
- Reset asserted mid-debounce or mid-update returns everything to reset values immediately. No event is produced for a key already held low when reset is released; the key must pass through a release first.

## Configuration
- HEX_ENTRY_WRAP_EN defined: ENTER when full still shifts. The oldest digit [4*NDIGITS−1:4*NDIGITS−4] is discarded, count stays at NDIGITS, and entry_valid pulses.
- HEX_ENTRY_WRAP_EN undefined: ENTER when full is ignored. digits is unchanged and entry_valid is not pulsed.

## Structure
- Package hex_entry_pkg contains:
  - the key index constants KEY_ENTER = 0, KEY_BKSP = 1, KEY_CLEAR = 2;
  - the debounce state enum;
  - the DEFAULT_DEBOUNCE_CYCLES and DEFAULT_NDIGITS constants.
- Sub-module key_debounce covers one key: synchronizer, FSM, counter and press pulse. It is instantiated three times.
- The top holds the edit datapath and the priority logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then idle for 20 cycles -> digits = 0, count = 0, full = 0, no pulses.
- sw_digit = 4'hA, ENTER held for 10 cycles -> key_event[0] at k+6. At k+7, digits = 32'h0000000A, count = 1, and entry_valid pulses for 1 cycle.
- Enter A, B, C, then BACKSPACE -> digits = 32'h000000AB, count = 2. Six more BACKSPACE presses -> digits = 0, count stays 0.
- 3-cycle low glitch on ENTER -> no key_event and no change.
- Enter 1..8, then ENTER with sw_digit = 9:
  - without WRAP: digits = 32'h12345678, no entry_valid;
  - with WRAP: digits = 32'h23456789, count = 8.
- CLEAR and ENTER presses aligned to the same edge -> digits = 0, count = 0, no entry_valid. Separately, rst_n asserted at debounce count 2 -> immediate reset values, and no event after release of reset.

Source files
------------

// File: rtl/hex_entry_pkg.sv
// Shared constants and types for the push-button hex entry block.
package hex_entry_pkg;

  localparam int KEY_ENTER = 0;
  localparam int KEY_BKSP  = 1;
  localparam int KEY_CLEAR = 2;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_NDIGITS         = 8;

  typedef enum logic [1:0] {
    DB_RELEASED    = 2'd0,
    DB_ARM_PRESS   = 2'd1,
    DB_PRESSED     = 2'd2,
    DB_ARM_RELEASE = 2'd3
  } db_state_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer, debounce FSM with stability counter,
// and a single-cycle press pulse. A key already held at reset release is
// ignored until it has been seen released.
module key_debounce
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1, r_sync2;
  logic [1:0]      r_sync_vld;
  logic            r_armed;
  db_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_press, w_press_nxt;

  // Synchronize the raw key; arm once a genuine (post-reset) released level is seen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && r_sync2) r_armed <= 1'b1;
    end
  end

  // Debounce state, counter and registered press pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DB_RELEASED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  // Next-state: each arm state needs TERM+1 consecutive samples of the new level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      DB_RELEASED: begin
        if (!r_sync2 && r_armed) begin
          w_state_nxt = DB_ARM_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      DB_ARM_PRESS: begin
        if (r_sync2) begin
          w_state_nxt = DB_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TERM) begin
          w_state_nxt = DB_PRESSED;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DB_PRESSED: begin
        if (r_sync2) begin
          w_state_nxt = DB_ARM_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      DB_ARM_RELEASE: begin
        if (!r_sync2) begin
          w_state_nxt = DB_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TERM) begin
          w_state_nxt = DB_RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = DB_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_press = r_press;

endmodule

// File: rtl/hex_key_entry.sv
// Debounced pushbutton hex entry: ENTER shifts in sw_digit, BACKSPACE drops
// the newest digit, CLEAR empties the value. Priority CLEAR > BKSP > ENTER.
// Build option HEX_ENTRY_WRAP_EN: ENTER when full discards the oldest digit
// instead of being ignored.
module hex_key_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NDIGITS         = DEFAULT_NDIGITS
) (
  input  logic                   CLOCK_50,
  input  logic                   rst_n,
  input  logic [2:0]             key_n,
  input  logic [3:0]             sw_digit,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [3:0]             count,
  output logic                   full,
  output logic                   entry_valid,
  output logic [2:0]             key_event
);

  localparam int DW = 4 * NDIGITS;
  localparam logic [3:0] NMAX = 4'(NDIGITS);

  logic [2:0]    w_kev;
  logic [DW-1:0] r_digits;
  logic [3:0]    r_count;
  logic          r_entry_valid;

  for (genvar g = 0; g < 3; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clk   (CLOCK_50),
      .i_rst_n (rst_n),
      .i_key_n (key_n[g]),
      .o_press (w_kev[g])
    );
  end

  // Edit datapath: apply the highest-priority event from the previous cycle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_digits      <= '0;
      r_count       <= '0;
      r_entry_valid <= 1'b0;
    end else begin
      r_entry_valid <= 1'b0;
      if (w_kev[KEY_CLEAR]) begin
        r_digits <= '0;
        r_count  <= '0;
      end else if (w_kev[KEY_BKSP]) begin
        if (r_count != 4'd0) begin
          r_digits <= {4'h0, r_digits[DW-1:4]};
          r_count  <= r_count - 4'd1;
        end
      end else if (w_kev[KEY_ENTER]) begin
        if (r_count != NMAX) begin
          r_digits      <= {r_digits[DW-5:0], sw_digit};
          r_count       <= r_count + 4'd1;
          r_entry_valid <= 1'b1;
        end
`ifdef HEX_ENTRY_WRAP_EN
        else begin
          r_digits      <= {r_digits[DW-5:0], sw_digit};
          r_entry_valid <= 1'b1;
        end
`endif
      end
    end
  end

  assign digits      = r_digits;
  assign count       = r_count;
  assign full        = (r_count == NMAX);
  assign entry_valid = r_entry_valid;
  assign key_event   = w_kev;

endmodule
